// File: rtl/linebuffer_kxk.sv
// KxK sliding-window generator over a raster pixel stream: K-1 line RAMs feed a registered, stallable window output.
// Optional LINEBUFFER_SOF_EN adds s_sof (forces frame start) and resync (partial frame abandoned).
module linebuffer_kxk #(
  parameter int PIX_W = 8,
  parameter int MAX_W = 128,
  parameter int K     = 3
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [$clog2(MAX_W+1)-1:0] img_w,
  input  logic [15:0]                img_h,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [PIX_W-1:0]           s_px,
`ifdef LINEBUFFER_SOF_EN
  input  logic                       s_sof,
  output logic                       resync,
`endif
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [K*K*PIX_W-1:0]       m_win,
  output logic                       m_last,
  output logic                       frame_done,
  output logic                       cfg_err
);
  localparam int CW = $clog2(MAX_W+1);
  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int L  = K - 1;
  localparam logic [CW-1:0] K_W    = CW'(K);
  localparam logic [CW-1:0] KM1_W  = CW'(K-1);
  localparam logic [CW-1:0] MAX_WC = CW'(MAX_W);
  localparam logic [CW-1:0] ONE_W  = CW'(1);
  localparam logic [15:0]   K_H    = 16'(K);
  localparam logic [15:0]   KM1_H  = 16'(K-1);

  logic [CW-1:0] col_q, col_d, w_q, w_d, col_cur, w_eff;
  logic [15:0]   row_q, row_d, h_q, h_d, row_cur, h_eff;
  logic          bad_q, bad_d, bad_eff, geo_bad, start, origin, acc, emit, is_last;
  logic          m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic          frame_done_q, frame_done_d, cfg_err_q, cfg_err_d;
  logic [K*K*PIX_W-1:0]    win_q, win_d;
  logic [K-1:0][PIX_W-1:0] vcol;
  logic [AW-1:0]           col_idx;
  logic [PIX_W-1:0]        line_mem [L][MAX_W];

  assign s_ready = rstn && (!m_valid_q || m_ready);
  assign acc     = s_valid && s_ready;
  assign origin  = (col_q == '0) && (row_q == '0);

`ifdef LINEBUFFER_SOF_EN
  logic resync_q, resync_d;
  assign start    = origin || s_sof;
  assign resync_d = acc && s_sof && !origin;
  assign resync   = resync_q;
  always_ff @(posedge clk) begin
    if (!rstn) resync_q <= 1'b0;
    else       resync_q <= resync_d;
  end
`else
  assign start = origin;
`endif

  always_comb begin
    geo_bad = (img_w < K_W) || (img_w > MAX_WC) || (img_h < K_H);
    // Geometry comes from the ports only on the frame's first pixel; a bad frame still runs on clamped counters.
    if (start) begin
      w_eff   = (img_w < K_W) ? K_W : ((img_w > MAX_WC) ? MAX_WC : img_w);
      h_eff   = (img_h < K_H) ? K_H : img_h;
      bad_eff = geo_bad;
      col_cur = '0;
      row_cur = '0;
    end else begin
      w_eff   = w_q;
      h_eff   = h_q;
      bad_eff = bad_q;
      col_cur = col_q;
      row_cur = row_q;
    end
    col_idx = col_cur[AW-1:0];
    for (int i = 0; i < L; i++) vcol[i] = line_mem[i][col_idx];
    vcol[K-1] = s_px;
    emit    = !bad_eff && (row_cur >= KM1_H) && (col_cur >= KM1_W);
    is_last = (col_cur == w_eff - ONE_W) && (row_cur == h_eff - 16'd1);

    col_d        = col_q;
    row_d        = row_q;
    w_d          = w_q;
    h_d          = h_q;
    bad_d        = bad_q;
    win_d        = win_q;
    cfg_err_d    = cfg_err_q;
    m_valid_d    = m_valid_q && !m_ready;
    m_last_d     = m_last_q && !m_ready;
    frame_done_d = 1'b0;
    if (acc) begin
      w_d       = w_eff;
      h_d       = h_eff;
      bad_d     = bad_eff;
      cfg_err_d = cfg_err_q || (start && geo_bad);
      if (is_last) begin
        col_d = '0;
        row_d = '0;
      end else if (col_cur == w_eff - ONE_W) begin
        col_d = '0;
        row_d = row_cur + 16'd1;
      end else begin
        col_d = col_cur + ONE_W;
        row_d = row_cur;
      end
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++)
          win_d[(r*K+c)*PIX_W +: PIX_W] = win_q[(r*K+c+1)*PIX_W +: PIX_W];
        win_d[(r*K+K-1)*PIX_W +: PIX_W] = vcol[r];
      end
      m_valid_d    = emit;
      m_last_d     = emit && is_last;
      frame_done_d = is_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      col_q        <= '0;
      row_q        <= '0;
      w_q          <= '0;
      h_q          <= '0;
      bad_q        <= 1'b0;
      win_q        <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      w_q          <= w_d;
      h_q          <= h_d;
      bad_q        <= bad_d;
      win_q        <= win_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Each line moves up one slot; the newest line takes the incoming pixel. Contents survive frames.
  always_ff @(posedge clk) begin
    if (acc)
      for (int i = 0; i < L; i++) line_mem[i][col_idx] <= vcol[i+1];
  end

  assign m_valid    = m_valid_q;
  assign m_win      = win_q;
  assign m_last     = m_last_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_linebuffer_kxk.sv
// Bench for linebuffer_kxk: K=3 and K=5 instances checked against a frame-array window model.
module tb_linebuffer_kxk;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  img_w = 8'd8;
  logic [15:0] img_h = 16'd6;
  logic [7:0]  s_px = 8'd0;
  logic        s_valid = 1'b0, s_sof = 1'b0, m_ready = 1'b1;
  int          sel = 0;
  bit          rdy_mode = 1'b0;
  logic        s_valid3, s_valid5, s_ready3, s_ready5;
  logic        m_valid3, m_valid5, m_last3, m_last5, fd3, fd5, ce3, ce5;
  logic [71:0]  m_win3;
  logic [199:0] m_win5;
  int vectors = 0, miscompares = 0;

  logic [7:0]   img [0:15][0:15];
  logic [71:0]  got3[$];
  bit           lst3[$];
  logic [199:0] got5[$];
  bit           lst5[$];
  int           stall_bad = 0, stall_seen = 0;
  logic [72:0]  hold3 = '0;
  logic         hold3_v = 1'b0;

  assign s_valid3 = s_valid && (sel == 0);
  assign s_valid5 = s_valid && (sel == 1);

`ifdef LINEBUFFER_SOF_EN
  logic resync3, resync5;
  int   resync_cnt = 0;
`endif

  linebuffer_kxk #(.PIX_W(8), .MAX_W(128), .K(3)) dut3 (
    .clk(clk), .rstn(rstn), .img_w(img_w), .img_h(img_h),
    .s_valid(s_valid3), .s_ready(s_ready3), .s_px(s_px),
`ifdef LINEBUFFER_SOF_EN
    .s_sof(s_sof), .resync(resync3),
`endif
    .m_valid(m_valid3), .m_ready(m_ready), .m_win(m_win3), .m_last(m_last3),
    .frame_done(fd3), .cfg_err(ce3));

  linebuffer_kxk #(.PIX_W(8), .MAX_W(16), .K(5)) dut5 (
    .clk(clk), .rstn(rstn), .img_w(img_w[4:0]), .img_h(img_h),
    .s_valid(s_valid5), .s_ready(s_ready5), .s_px(s_px),
`ifdef LINEBUFFER_SOF_EN
    .s_sof(1'b0), .resync(resync5),
`endif
    .m_valid(m_valid5), .m_ready(m_ready), .m_win(m_win5), .m_last(m_last5),
    .frame_done(fd5), .cfg_err(ce5));

  always begin
    @(posedge clk); #1;
    m_ready = rdy_mode ? !m_ready : 1'b1;
  end

  // Collect transferred windows; track stall stability of the K=3 output.
  always @(negedge clk) begin
    if (m_valid3 && m_ready) begin got3.push_back(m_win3); lst3.push_back(m_last3); end
    if (m_valid5 && m_ready) begin got5.push_back(m_win5); lst5.push_back(m_last5); end
    if ((hold3_v && m_valid3 && {m_last3, m_win3} !== hold3) || (m_valid3 && !m_ready && s_ready3))
      stall_bad <= stall_bad + 1;
    if (m_valid3 && !m_ready) stall_seen <= stall_seen + 1;
    hold3_v <= m_valid3 && !m_ready;
    hold3   <= {m_last3, m_win3};
`ifdef LINEBUFFER_SOF_EN
    if (resync3) resync_cnt <= resync_cnt + 1;
`endif
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [199:0] exp_win(input int k, input int r, input int c);
    logic [199:0] e = '0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++) e[(i*k+j)*8 +: 8] = img[r-k+1+i][c-k+1+j];
    return e;
  endfunction

  task automatic fill_pattern();
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = 8'(r*16 + c);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom);
  endtask

  task automatic send_px(input int s, input logic [7:0] px, input bit sof, input bit gap);
    bit rdy = 1'b0;
    int n = 0;
    if (gap) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    sel = s; s_px = px; s_sof = sof; s_valid = 1'b1;
    while (!rdy && n < 64) begin
      @(negedge clk);
      rdy = (s == 1) ? s_ready5 : s_ready3;
      @(posedge clk); #1;
      n++;
    end
    s_valid = 1'b0; s_sof = 1'b0;
    if (!rdy) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: pixel not accepted after %0d cycles, required acceptance", n);
    end
  endtask

  task automatic send_frame(input int s, input int w, input int h, input int npx,
                            input bit sof, input bit gap, input bit chk_end, input bit scramble);
    logic [2:0] flags;
    img_w = 8'(w); img_h = 16'(h);
    for (int p = 0; p < npx; p++) begin
      send_px(s, img[p/w][p%w], sof && (p == 0), gap);
      if (p == 0 && scramble) begin
        img_w = 8'($urandom_range(3, 15)); img_h = 16'($urandom_range(3, 15));
      end
    end
    if (chk_end) begin
      flags = (s == 1) ? {m_valid5, m_last5, fd5} : {m_valid3, m_last3, fd3};
      vectors++;
      if (flags !== 3'b111) begin
        miscompares++; $display("FAIL end_flags: valid/last/done got %b want 111", flags);
      end
      @(posedge clk); #1;
      flags[0] = (s == 1) ? fd5 : fd3;
      vectors++;
      if (flags[0] !== 1'b0) begin
        miscompares++; $display("FAIL frame_done_width: got %b want 0", flags[0]);
      end
    end
  endtask

  task automatic check_frame(input string tag, input int s, input int w, input int h,
                             input int base, input bit exact);
    int k, nx, n, t, r, c;
    logic [199:0] e, g;
    bit l;
    k  = (s == 1) ? 5 : 3;
    nx = (w-k+1) * (h-k+1);
    t  = 0;
    n  = ((s == 1) ? got5.size() : got3.size()) - base;
    while (n < nx && t < 500) begin
      @(posedge clk); #1; t++;
      n = ((s == 1) ? got5.size() : got3.size()) - base;
    end
    repeat (4) begin @(posedge clk); #1; end
    n = ((s == 1) ? got5.size() : got3.size()) - base;
    vectors++;
    if (exact ? (n != nx) : (n < nx)) begin
      miscompares++; $display("FAIL %s count: got %0d want %0d", tag, n, nx);
    end
    for (int i = 0; i < nx && i < n; i++) begin
      r = k-1 + i/(w-k+1);
      c = k-1 + i%(w-k+1);
      e = exp_win(k, r, c);
      g = (s == 1) ? got5[base+i] : {128'd0, got3[base+i]};
      l = (s == 1) ? lst5[base+i] : lst3[base+i];
      vectors++;
      if (g !== e || l !== (i == nx-1)) begin
        miscompares++;
        $display("FAIL %s win[%0d]: got %h last %0d want %h last %0d", tag, i, g, l, e, (i == nx-1));
      end
    end
  endtask

  task automatic test_reset(input string tag);
    s_valid = 1'b0; s_sof = 1'b0; rstn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if ({m_valid3, m_last3, fd3, ce3, s_ready3, m_valid5, s_ready5, ce5} !== 8'b0) begin
      miscompares++;
      $display("FAIL %s reset_outs: got %b want 00000000", tag,
               {m_valid3, m_last3, fd3, ce3, s_ready3, m_valid5, s_ready5, ce5});
    end
    vectors++;
    if (m_win3 !== 72'd0 || m_win5 !== 200'd0) begin
      miscompares++; $display("FAIL %s reset_win: got %h want 0", tag, m_win3);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (s_ready3 !== 1'b1) begin
      miscompares++; $display("FAIL %s ready_after_reset: got %b want 1", tag, s_ready3);
    end
  endtask

  task automatic test_basic();
    int base = got3.size();
    fill_pattern();
    send_frame(0, 8, 6, 48, 1'b0, 1'b0, 1'b1, 1'b0);
    check_frame("basic", 0, 8, 6, base, 1'b1);
    vectors++;
    if (got3.size() < base + 24 ||
        {got3[base][7:0], got3[base][39:32], got3[base][71:64]} !== 24'h001122) begin
      miscompares++; $display("FAIL basic_first: w00/w11/w22 wrong, want 00 11 22");
    end
    vectors++;
    if (got3.size() < base + 24 || got3[base+23][71:64] !== 8'h57 || lst3[base+23] !== 1'b1) begin
      miscompares++; $display("FAIL basic_last: last window w22 wrong or no last, want 57 last 1");
    end
  endtask

  task automatic test_backpressure();
    int base = got3.size();
    int sb = stall_bad;
    int ss = stall_seen;
    fill_pattern();
    rdy_mode = 1'b1;
    send_frame(0, 8, 6, 48, 1'b0, 1'b1, 1'b1, 1'b0);
    check_frame("backpressure", 0, 8, 6, base, 1'b1);
    rdy_mode = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (stall_bad - sb !== 0) begin
      miscompares++; $display("FAIL stall_stable: %0d violations, want 0", stall_bad - sb);
    end
    vectors++;
    if (stall_seen - ss <= 0) begin
      miscompares++; $display("FAIL stall_exercised: %0d stall cycles, want >0", stall_seen - ss);
    end
  endtask

  task automatic test_k5();
    int base = got5.size();
    fill_pattern();
    send_frame(1, 10, 7, 70, 1'b0, 1'b0, 1'b1, 1'b0);
    check_frame("k5", 1, 10, 7, base, 1'b1);
    vectors++;
    if (got5.size() < base + 1 ||
        {got5[base][7:0], got5[base][103:96], got5[base][199:192]} !== 24'h002244) begin
      miscompares++; $display("FAIL k5_first: w00/centre/w44 wrong, want 00 22 44");
    end
  endtask

  task automatic test_back_to_back();
    int w1 = $urandom_range(3, 12), h1 = $urandom_range(3, 8);
    int w2 = $urandom_range(3, 12), h2 = $urandom_range(3, 8);
    int base = got3.size();
    fill_rand();
    rdy_mode = bit'($urandom_range(0, 1));
    send_frame(0, w1, h1, w1*h1, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(0, w2, h2, w2*h2, 1'b0, 1'b1, 1'b1, 1'b1);
    check_frame("b2b_a", 0, w1, h1, base, 1'b0);
    check_frame("b2b_b", 0, w2, h2, base + (w1-2)*(h1-2), 1'b1);
    rdy_mode = 1'b0;
  endtask

  task automatic test_cfg_err();
    int base = got3.size();
    fill_rand();
    vectors++;
    if (ce3 !== 1'b0) begin miscompares++; $display("FAIL cfg_err_pre: got %b want 0", ce3); end
    img_w = 8'd2; img_h = 16'd6;
    send_px(0, img[0][0], 1'b0, 1'b0);
    vectors++;
    if (ce3 !== 1'b1) begin miscompares++; $display("FAIL cfg_err_set: got %b want 1", ce3); end
    for (int p = 1; p < 18; p++) send_px(0, img[p/3][p%3], 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    vectors++;
    if (got3.size() != base) begin
      miscompares++; $display("FAIL cfg_err_windows: got %0d want 0", got3.size() - base);
    end
    base = got3.size();
    send_frame(0, 8, 6, 48, 1'b0, 1'b0, 1'b1, 1'b0);
    check_frame("after_bad", 0, 8, 6, base, 1'b1);
    vectors++;
    if (ce3 !== 1'b1) begin miscompares++; $display("FAIL cfg_err_sticky: got %b want 1", ce3); end
  endtask

  task automatic test_mid_reset();
    int base;
    fill_rand();
    send_frame(0, 8, 6, 20, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset("mid");
    base = got3.size();
    fill_pattern();
    send_frame(0, 8, 6, 48, 1'b0, 1'b0, 1'b1, 1'b0);
    check_frame("mid_reset", 0, 8, 6, base, 1'b1);
  endtask

`ifdef LINEBUFFER_SOF_EN
  task automatic test_sof();
    int base = got3.size();
    int rc = resync_cnt;
    fill_rand();
    send_frame(0, 8, 6, 13, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8, 6, 48, 1'b1, 1'b0, 1'b1, 1'b0);
    check_frame("sof", 0, 8, 6, base, 1'b1);
    vectors++;
    if (resync_cnt - rc !== 1) begin
      miscompares++; $display("FAIL sof_resync: %0d pulse cycles, want 1", resync_cnt - rc);
    end
  endtask
`endif

  initial begin
    test_reset("por");
    test_basic();
    test_backpressure();
    test_k5();
    repeat (3) test_back_to_back();
    test_cfg_err();
    test_mid_reset();
`ifdef LINEBUFFER_SOF_EN
    test_sof();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
